uart_tx_frame_ctrl: RTL
=======================

// Module: uart_tx_frame_ctrl
// PURPOSE
//  UART TX framing stage that consumes par_bit from tx_parity_calc.
//  Accepts a parallel word and serialises one frame: start bit, data (LSB first),
//  optional parity bit, then stop bit.
//  Runs at one bit per clk cycle; clk is the TX bit clock.
//  tx_parity_calc is driven from the same p_data/data_valid and returns par_bit.
// PARAMETERS
//  data_width  8  width of p_data, and the number of data bits per frame
// PORTS
//  clk         in   1           TX bit clock; single clock domain
//  rst         in   1           synchronous, active-high reset
//  p_data      in   data_width  parallel word; sampled on the accept cycle
//  data_valid  in   1           request to send p_data; also feeds tx_parity_calc
//  par_en      in   1           1 = insert parity bit; sampled on the accept cycle
//  par_bit     in   1           registered parity from tx_parity_calc; valid 1 cycle after accept
//  tx_out      out  1           serial line, registered; idle level 1
//  busy        out  1           1 while a frame is on tx_out, registered
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, tx_out=1, busy=0, shift reg=0,
//   bit counter=0, par_q=0, par_en_q=0. Applies mid-frame: frame aborts,
//   line returns to 1 on the next edge, no partial stop bit.
//  Accept = data_valid & (state==IDLE | state==STOP).
//   On accept: latch p_data -> shift reg, par_en -> par_en_q, next state START.
//   data_valid in START/DATA/PARITY is ignored. Upstream holds data_valid low while busy=1.
//  FSM (state is registered; tx_out shows the bit of the current state):
//   IDLE  : tx_out=1, busy=0; go to START on accept.
//   START : tx_out=0, busy=1; sample par_bit -> par_q; go to DATA.
//   DATA  : tx_out=shift[0]; shift right each cycle; counter 0..data_width-1.
//           At count==data_width-1: go to PARITY if par_en_q, else STOP; clear counter.
//   PARITY: tx_out=par_q; go to STOP.
//   STOP  : tx_out=1, busy=1; accept -> START (back-to-back, no idle gap), else IDLE.
//  Latency: tx_out falls to 0 on the first edge after the accept edge.
//  Frame length: data_width+2 cycles, or data_width+3 cycles with parity.
//  Counter width: $clog2(data_width); no wrap in normal operation, because it clears on leaving DATA.
//  par_q is captured in START, so a back-to-back accept in STOP (which re-arms
//   tx_parity_calc) cannot corrupt the parity of the frame being sent.
//  tx_out and busy come straight from flops; no combinational path from inputs.
// STRUCTURE
//  uart_tx_defs.vh (shared header): state encodings IDLE/START/DATA/PARITY/STOP
//   (3-bit), START_BIT=1'b0, STOP_BIT=1'b1.
//  Sub-module uart_tx_serializer:
//   - shift register and bit counter
//   - ports: clk, rst, load, p_data, shift_en, ser_data, ser_done
//   - FSM and output register stay in uart_tx_frame_ctrl.
//  Top-level uart_tx instantiates tx_parity_calc and uart_tx_frame_ctrl, sharing p_data/data_valid.
// TESTING (data_width=8; bench includes tx_parity_calc; cycles count from the accept edge)
//  1 Reset: rst=1 for 2 cycles with data_valid=1 -> tx_out=1, busy=0 throughout, no frame starts.
//  2 Even parity, p_data=8'hA9, par_typ=0, par_en=1, one-cycle data_valid ->
//     tx_out = 0,1,0,0,1,0,1,0,1,0,1 over 11 cycles; busy=1 for those 11 cycles, then 0.
//  3 Odd parity, p_data=8'hAD, par_typ=1 -> parity bit 0; same with par_typ=0 -> parity bit 1.
//  4 No parity, p_data=8'h55, par_en=0 -> tx_out = 0,1,0,1,0,1,0,1,0,1 (10 cycles), then idle 1.
//  5 Back-to-back: hold data_valid, send 8'hA9 then 8'hAD (par_en=1, even) ->
//     second start bit immediately follows the first stop bit; parity bits 0 then 1; busy never drops.
//  6 Mid-frame reset: rst=1 at cycle 5 of a frame -> next edge tx_out=1, busy=0, state IDLE;
//     a new frame then sends correctly.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART TX framing stage.
//   tx_state_e  : 3-bit FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   START_BIT   : line level of the start bit
//   STOP_BIT    : line level of the stop bit (also the idle level)
//   cnt_width() : bit-counter width for a given data width (at least 1)
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // $clog2(1) is 0, which would give a zero-width counter; clamp to 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the UART TX data phase.
// Ports:
//   clk      in   TX bit clock
//   rst      in   synchronous active-high reset
//   load     in   capture p_data into the shift register, clear the counter
//   p_data   in   parallel word to serialise
//   shift_en in   shift right by one and advance the counter
//   ser_data out  current data bit (shift register LSB)
//   ser_done out  high while the counter points at the last data bit
module uart_tx_serializer
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [data_width-1:0] p_data,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int cw = cnt_width(data_width);
  localparam logic [cw-1:0] last_cnt = cw'(data_width - 1);

  logic [data_width-1:0] shift_q;
  logic [cw-1:0]         cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= p_data;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
      // Clearing on the last bit keeps the counter from wrapping and leaves
      // it at zero for the next frame.
      cnt_q   <= ser_done ? '0 : cnt_q + cw'(1);
    end
  end

  assign ser_data = shift_q[0];
  assign ser_done = (cnt_q == last_cnt);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing stage: serialises one frame per accepted word as
// start bit, data bits (LSB first), optional parity bit, stop bit,
// at one bit per clk cycle.
// Ports:
//   clk        in   TX bit clock
//   rst        in   synchronous active-high reset (aborts a frame in flight)
//   p_data     in   parallel word, sampled on the accept cycle
//   data_valid in   request to send p_data
//   par_en     in   1 = insert a parity bit, sampled on the accept cycle
//   par_bit    in   registered parity from tx_parity_calc, valid one cycle
//                   after accept
//   tx_out     out  serial line (registered, idles at 1)
//   busy       out  high while a frame is on tx_out (registered)
//   fsm_state  out  current FSM state, for observation
//
// Handshake: a word is accepted on any clk edge where data_valid=1 and the
// FSM is in IDLE or STOP; there is no ready signal. data_valid in START,
// DATA or PARITY is ignored, and upstream keeps it low while busy=1 except
// to chain a frame back-to-back during STOP.
//
// tx_out/busy are registered from the current state, so the line shows a
// state's bit one cycle after the state is entered: the start bit appears on
// the first edge after the accept edge.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_bit,
  output logic                  tx_out,
  output logic                  busy,
  output logic [2:0]            fsm_state
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_q;
  logic      par_en_q;
  logic      accept;
  logic      shift_en;
  logic      ser_data;
  logic      ser_done;

  assign accept = data_valid & ((state_q == ST_IDLE) | (state_q == ST_STOP));

  uart_tx_serializer #(
    .data_width(data_width)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .p_data   (p_data),
    .shift_en (shift_en),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = STOP_BIT;
    busy_d   = 1'b1;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        tx_d    = START_BIT;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d     = ser_data;
        shift_en = 1'b1;
        if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_d    = par_q;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        tx_d    = STOP_BIT;
        // Chaining straight into START avoids an idle gap between frames.
        state_d = accept ? ST_START : ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (accept) par_en_q <= par_en;
      // Capture parity in START: a back-to-back accept in STOP re-arms
      // tx_parity_calc, so par_bit cannot be read later in the frame.
      if (state_q == ST_START) par_q <= par_bit;
    end
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign fsm_state = state_q;

endmodule
